// File: rtl/intersection_phase_scheduler.sv
// Two-approach (NS/EW) intersection controller with all-red clearance and
// latched detector demand. Optional preemption is enabled by EMERGENCY_PREEMPT_EN.
module intersection_phase_scheduler #(
    parameter int unsigned GREEN_MIN    = 20,
    parameter int unsigned GREEN_MAX    = 60,
    parameter int unsigned YELLOW_TIME  = 5,
    parameter int unsigned ALL_RED_TIME = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_ns,
    input  logic       det_ew,
    input  logic       preempt,
    input  logic       preempt_dir,
    output logic [2:0] sig_ns,
    output logic [2:0] sig_ew,
    output logic [2:0] phase,
    output logic       gnt_ns,
    output logic       gnt_ew
);

    localparam logic [2:0] RED    = 3'b000;
    localparam logic [2:0] YELLOW = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED_TIME - 1);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             pend_ns;
    logic             pend_ew;
    logic             ns_release;
    logic             ew_release;
    logic             enter_ns;
    logic             enter_ew;
    logic             in_green;

`ifndef EMERGENCY_PREEMPT_EN
    logic preempt_unused;
    assign preempt_unused = preempt ^ preempt_dir;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= AR_EW;
        else     state <= state_next;
    end

    // Next-state logic and green-termination decisions
    always_comb begin
        state_next = state;
        ns_release = pend_ew && (cnt >= GMIN_M1) && (!det_ns || (cnt == GMAX_M1));
        ew_release = pend_ns && (cnt >= GMIN_M1) && (!det_ew || (cnt == GMAX_M1));
`ifdef EMERGENCY_PREEMPT_EN
        // Preemption forces the opposing green out and pins the target green
        if (preempt) begin
            ns_release = preempt_dir;
            ew_release = !preempt_dir;
        end
`endif
        case (state)
            NS_G:    if (ns_release)      state_next = NS_Y;
            NS_Y:    if (cnt == YEL_M1)   state_next = AR_NS;
            AR_NS:   if (cnt == AR_M1)    state_next = EW_G;
            EW_G:    if (ew_release)      state_next = EW_Y;
            EW_Y:    if (cnt == YEL_M1)   state_next = AR_EW;
            AR_EW:   if (cnt == AR_M1)    state_next = NS_G;
            default:                      state_next = AR_EW;
        endcase
    end

    assign enter_ns = (state_next == NS_G) && (state != NS_G);
    assign enter_ew = (state_next == EW_G) && (state != EW_G);
    assign in_green = (state == NS_G) || (state == EW_G);
    assign phase    = state;

    // Phase timer: clears on entry, saturates during green, never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (!(in_green && (cnt == GMAX_M1)) && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Demand latches; entering the approach's green clears it and wins over a set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_ns <= 1'b0;
            pend_ew <= 1'b0;
        end else begin
            pend_ns <= enter_ns ? 1'b0 : (pend_ns || (det_ns && (state != NS_G)));
            pend_ew <= enter_ew ? 1'b0 : (pend_ew || (det_ew && (state != EW_G)));
        end
    end

    // Heads decoded from the upcoming state so they change with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_ns <= RED;
            sig_ew <= RED;
            gnt_ns <= 1'b0;
            gnt_ew <= 1'b0;
        end else begin
            sig_ns <= (state_next == NS_G) ? GREEN : (state_next == NS_Y) ? YELLOW : RED;
            sig_ew <= (state_next == EW_G) ? GREEN : (state_next == EW_Y) ? YELLOW : RED;
            gnt_ns <= enter_ns;
            gnt_ew <= enter_ew;
        end
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler against a phase/timer
// reference model; preemption scenarios are exercised when EMERGENCY_PREEMPT_EN is defined.
module tb_intersection_phase_scheduler;

    localparam int GMIN = 20;
    localparam int GMAX = 60;
    localparam int YT   = 5;
    localparam int ART  = 2;
    localparam logic [2:0] RED    = 3'b000;
    localparam logic [2:0] YELLOW = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       det_ns = 1'b0;
    logic       det_ew = 1'b0;
    logic       preempt = 1'b0;
    logic       preempt_dir = 1'b0;
    logic [2:0] sig_ns;
    logic [2:0] sig_ew;
    logic [2:0] phase;
    logic       gnt_ns;
    logic       gnt_ew;
    logic [10:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase index = 3*approach + sub (0 green, 1 yellow, 2 all-red)
    int m_ph;
    int m_t;
    bit m_pn, m_pe, m_gn, m_ge;

    intersection_phase_scheduler dut (
        .clk(clk), .rst(rst), .det_ns(det_ns), .det_ew(det_ew),
        .preempt(preempt), .preempt_dir(preempt_dir),
        .sig_ns(sig_ns), .sig_ew(sig_ew), .phase(phase),
        .gnt_ns(gnt_ns), .gnt_ew(gnt_ew)
    );

    always #5 clk = ~clk;

    assign obs = {sig_ns, sig_ew, phase, gnt_ns, gnt_ew};

    function automatic logic [2:0] head(input int approach);
        if (m_ph / 3 != approach) return RED;
        case (m_ph % 3)
            0:       return GREEN;
            1:       return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic logic [10:0] expv();
        return {head(0), head(1), 3'(m_ph), 1'(m_gn), 1'(m_ge)};
    endfunction

    task automatic model_reset();
        m_ph = 5; m_t = 0; m_pn = 0; m_pe = 0; m_gn = 0; m_ge = 0;
    endtask

    task automatic model_step(input bit dn, input bit de);
        int a, nxt;
        bit own_det, opp_pend, rel;
        a = m_ph / 3;
        nxt = m_ph;
        own_det  = (a == 0) ? dn : de;
        opp_pend = (a == 0) ? m_pe : m_pn;
        case (m_ph % 3)
            0: begin
                rel = opp_pend && (m_t >= GMIN - 1) && (!own_det || m_t >= GMAX - 1);
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt) rel = (int'(preempt_dir) != a);
`endif
                if (rel) nxt = m_ph + 1;
            end
            1: if (m_t == YT - 1) nxt = m_ph + 1;
            default: if (m_t == ART - 1) nxt = (m_ph + 1) % 6;
        endcase
        m_gn = (nxt == 0) && (m_ph != 0);
        m_ge = (nxt == 3) && (m_ph != 3);
        m_pn = (m_pn || (dn && m_ph != 0)) && !m_gn;
        m_pe = (m_pe || (de && m_ph != 3)) && !m_ge;
        m_t  = (nxt == m_ph) ? m_t + 1 : 0;
        m_ph = nxt;
    endtask

    // Drive detectors for one cycle; called and returns at a falling edge
    task automatic tick(input bit dn, input bit de);
        det_ns = dn;
        det_ew = de;
        model_step(dn, de);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        preempt = 1'b0;
        det_ns = 1'b0;
        det_ew = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 11'b000_000_101_0_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, 11'b000_000_101_0_0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (phase !== 3'd5 || sig_ns !== RED) begin
                n_fail++;
                $display("FAIL reset_allred[%0d]: phase %0d sig_ns %b expected 5 000", i, phase, sig_ns);
            end
            tick(0, 0);
        end
        n_checks++;
        if (sig_ns !== GREEN || gnt_ns !== 1'b1 || phase !== 3'd0) begin
            n_fail++;
            $display("FAIL first_green: sig_ns %b gnt_ns %b phase %0d expected 010 1 0", sig_ns, gnt_ns, phase);
        end
        for (int i = 0; i < 100; i++) begin
            tick(0, 0);
            n_checks++;
            if (obs !== expv() || sig_ew !== RED || sig_ns !== GREEN) begin
                n_fail++;
                $display("FAIL ns_rest[%0d]: got %b expected %b", i, obs, expv());
            end
        end
    endtask

    task automatic test_single_request();
        int len;
        do_reset();
        tick(0, 0);
        tick(0, 0);
        len = 0;
        while (sig_ns === GREEN && len < 200) begin
            len++;
            tick(0, len == 4);
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL single_green_cycle[%0d]: got %b expected %b", len, obs, expv());
            end
        end
        n_checks++;
        if (len != GMIN) begin
            n_fail++;
            $display("FAIL single_green_len: got %0d expected %0d", len, GMIN);
        end
        len = 0;
        while (sig_ns === YELLOW && len < 50) begin len++; tick(0, 0); end
        n_checks++;
        if (len != YT) begin
            n_fail++;
            $display("FAIL single_yellow_len: got %0d expected %0d", len, YT);
        end
        len = 0;
        while (phase === 3'd2 && len < 50) begin len++; tick(0, 0); end
        n_checks++;
        if (len != ART) begin
            n_fail++;
            $display("FAIL single_allred_len: got %0d expected %0d", len, ART);
        end
        n_checks++;
        if (sig_ew !== GREEN || gnt_ew !== 1'b1 || sig_ns !== RED) begin
            n_fail++;
            $display("FAIL ew_grant: sig_ew %b gnt_ew %b sig_ns %b expected 010 1 000", sig_ew, gnt_ew, sig_ns);
        end
        tick(0, 0);
        n_checks++;
        if (gnt_ew !== 1'b0 || sig_ew !== GREEN) begin
            n_fail++;
            $display("FAIL ew_grant_pulse: gnt_ew %b sig_ew %b expected 0 010", gnt_ew, sig_ew);
        end
    endtask

    task automatic test_extension();
        int len;
        do_reset();
        tick(0, 0);
        tick(0, 0);
        len = 0;
        while (sig_ns === GREEN && len < 200) begin
            len++;
            tick(1, len == 1);
        end
        n_checks++;
        if (len != GMAX) begin
            n_fail++;
            $display("FAIL extension_len: got %0d expected %0d", len, GMAX);
        end
        n_checks++;
        if (sig_ns !== YELLOW || phase !== 3'd1) begin
            n_fail++;
            $display("FAIL extension_yellow: sig_ns %b phase %0d expected 001 1", sig_ns, phase);
        end
    endtask

    task automatic test_back_to_back();
        int run, runs;
        do_reset();
        run = 0;
        runs = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1, 1);
            n_checks++;
            if (obs !== expv() || (sig_ns !== RED && sig_ew !== RED)) begin
                n_fail++;
                $display("FAIL b2b_cycle[%0d]: got %b expected %b", i, obs, expv());
            end
            if (sig_ns === GREEN || sig_ew === GREEN) begin
                run++;
            end else if (run > 0) begin
                runs++;
                n_checks++;
                if (run != GMAX) begin
                    n_fail++;
                    $display("FAIL b2b_green_len[%0d]: got %0d expected %0d", runs, run, GMAX);
                end
                run = 0;
            end
        end
        n_checks++;
        if (runs < 4) begin
            n_fail++;
            $display("FAIL b2b_alternations: got %0d expected at least 4", runs);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        guard = 0;
        while (!(m_ph == 4 && m_t == 2) && guard < 500) begin
            guard++;
            tick(m_ph >= 3, m_ph < 3);
        end
        n_checks++;
        if (sig_ew !== YELLOW || phase !== 3'd4) begin
            n_fail++;
            $display("FAIL pre_reset_ew_y: sig_ew %b phase %0d expected 001 4", sig_ew, phase);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 11'b000_000_101_0_0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", obs, 11'b000_000_101_0_0);
        end
        model_reset();
        det_ns = 1'b0;
        det_ew = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL restart[%0d]: got %b expected %b", i, obs, expv());
            end
        end
        n_checks++;
        if (sig_ns !== GREEN) begin
            n_fail++;
            $display("FAIL restart_ns_green: sig_ns %b expected 010", sig_ns);
        end
    endtask

    task automatic test_random();
        bit dn, de;
        do_reset();
        dn = 0;
        de = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) dn = ~dn;
            if ($urandom_range(0, 15) == 0) de = ~de;
            if ($urandom_range(0, 60) == 0) preempt = ~preempt;
            if ($urandom_range(0, 80) == 0) preempt_dir = ~preempt_dir;
            tick(dn ^ ($urandom_range(0, 7) == 0), de ^ ($urandom_range(0, 7) == 0));
            n_checks++;
            if (obs !== expv() || (sig_ns !== RED && sig_ew !== RED)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b expected %b", i, obs, expv());
            end
        end
        preempt = 1'b0;
    endtask

`ifdef EMERGENCY_PREEMPT_EN
    task automatic test_preempt();
        int len;
        do_reset();
        repeat (6) tick(0, 0);
        preempt = 1'b1;
        preempt_dir = 1'b1;
        tick(0, 0);
        n_checks++;
        if (phase !== 3'd1 || sig_ns !== YELLOW) begin
            n_fail++;
            $display("FAIL preempt_yellow: phase %0d sig_ns %b expected 1 001", phase, sig_ns);
        end
        len = 1;
        while (sig_ew !== GREEN && len < 50) begin len++; tick(0, 0); end
        n_checks++;
        if (len != YT + ART + 1 || gnt_ew !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_latency: got %0d gnt_ew %b expected %0d 1", len - 1, gnt_ew, YT + ART);
        end
        for (int i = 0; i < 100; i++) begin
            tick(1, 0);
            n_checks++;
            if (sig_ew !== GREEN || obs !== expv()) begin
                n_fail++;
                $display("FAIL preempt_hold[%0d]: got %b expected %b", i, obs, expv());
            end
        end
        preempt = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(i < 5, 0);
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL preempt_resume[%0d]: got %b expected %b", i, obs, expv());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_request();
        test_extension();
        test_back_to_back();
        test_reset_mid();
`ifdef EMERGENCY_PREEMPT_EN
        test_preempt();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
